// File: rtl/instr_ram_responder.sv
// rtl/instr_ram_responder.sv - instruction RAM responder with RUN/LOAD program-load port
module instr_ram_responder #(
    parameter int          AW        = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter bit          BOOT_LOAD = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_ram_rd,
    input  logic [AW-1:0] instr_ram_addr,
    output logic [31:0]   instr_ram_din,
    output logic          core_stall,
    input  logic          ld_start,
    input  logic          ld_done,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic [3:0]    ld_be,
    output logic [AW:0]   ld_count
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam state_t      RESET_STATE = BOOT_LOAD ? LOAD : RUN;
    localparam logic [AW:0] COUNT_MAX   = (AW + 1)'(1) << AW;

    state_t state;
    state_t state_next;
    logic   accept;

    logic [31:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_stall = 1'b0;
        ld_ready   = 1'b0;
        case (state)
            RUN: begin
                if (ld_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                core_stall = 1'b1;
                ld_ready   = 1'b1;
                if (ld_done) begin
                    state_next = RUN;
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    assign accept = ld_valid & ld_ready;

    // Reads and writes live in disjoint states, so the single port never sees both at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ram_din <= NOP_INSTR;
        end else if (instr_ram_rd) begin
            instr_ram_din <= (state == RUN) ? mem[instr_ram_addr] : NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_count <= '0;
        end else if (state == RUN && ld_start) begin
            ld_count <= '0;
        end else if (accept && ld_count != COUNT_MAX) begin
            ld_count <= ld_count + (AW + 1)'(1);
        end
    end

    // RAM contents deliberately survive reset so an interrupted load keeps its words.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (ld_be[i]) begin
                    mem[ld_addr][8*i +: 8] <= ld_data[8*i +: 8];
                end
            end
        end
    end

endmodule
